// File: rtl/melody_sequencer.sv
// Melody sequencer: steps through a fixed note table and drives the tone divider.
// Optional build macro MELODY_LOOP_EN adds a 'loop' input that restarts the song instead of ending it.
module melody_sequencer #(
    parameter logic [27:0] TEMPO_DIV  = 28'd6000000,
    parameter logic [27:0] GAP_CYCLES = 28'd1200000,
    parameter int          SONG_LEN   = 8
) (
    input  logic        clock_in,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
`ifdef MELODY_LOOP_EN
    input  logic        loop,
`endif
    output logic [27:0] tone_divisor,
    output logic        tone_en,
    output logic [3:0]  step,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_PLAY = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [3:0] LAST_STEP = 4'(SONG_LEN - 1);

    // Table entry packs {code[3:0], dur[2:0]}; entries past SONG_LEN are never reached.
    function automatic logic [6:0] rom_entry(input logic [3:0] idx);
        logic [6:0] e;
        case (idx)
            4'd0:    e = {4'd1,  3'd2};
            4'd1:    e = {4'd3,  3'd2};
            4'd2:    e = {4'd5,  3'd2};
            4'd3:    e = {4'd6,  3'd2};
            4'd4:    e = {4'd8,  3'd4};
            4'd5:    e = {4'd0,  3'd1};
            4'd6:    e = {4'd8,  3'd4};
            4'd7:    e = {4'd1,  3'd7};
            4'd8:    e = {4'd10, 3'd2};
            4'd9:    e = {4'd8,  3'd2};
            4'd10:   e = {4'd6,  3'd2};
            4'd11:   e = {4'd5,  3'd2};
            4'd12:   e = {4'd3,  3'd2};
            4'd13:   e = {4'd1,  3'd4};
            4'd14:   e = {4'd0,  3'd1};
            default: e = {4'd1,  3'd4};
        endcase
        return e;
    endfunction

    function automatic logic [27:0] code_divisor(input logic [3:0] code);
        logic [27:0] d;
        case (code)
            4'd1:    d = 28'd91733;
            4'd2:    d = 28'd86586;
            4'd3:    d = 28'd81727;
            4'd4:    d = 28'd77138;
            4'd5:    d = 28'd72810;
            4'd6:    d = 28'd68723;
            4'd7:    d = 28'd64867;
            4'd8:    d = 28'd61224;
            4'd9:    d = 28'd57790;
            4'd10:   d = 28'd54545;
            4'd11:   d = 28'd51484;
            4'd12:   d = 28'd48595;
            default: d = 28'd0;
        endcase
        return d;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [27:0] cnt_q, cnt_d;
    logic [2:0]  beats_q, beats_d;
    logic [27:0] div_q, div_d;
    logic        en_q, en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [6:0]  entry;
    logic [3:0]  cur_code;
    logic [2:0]  cur_dur;
    logic        tick;
    logic        gap_end;
    logic        last_step;

    assign entry     = rom_entry(step_q);
    assign cur_code  = entry[6:3];
    assign cur_dur   = entry[2:0];
    assign tick      = (cnt_q == TEMPO_DIV - 28'd1);
    assign gap_end   = (GAP_CYCLES == 28'd0) || (cnt_q == GAP_CYCLES - 28'd1);
    assign last_step = (step_q >= LAST_STEP);

    always_comb begin
        // NOTE: every next-state value defaults to its register so no branch below can infer a latch.
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        beats_d = beats_q;
        div_d   = div_q;
        en_d    = en_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_LOAD;
                    step_d  = 4'd0;
                    cnt_d   = 28'd0;
                end
            end
            S_LOAD: begin
                div_d   = code_divisor(cur_code);
                en_d    = (cur_code >= 4'd1) && (cur_code <= 4'd12);
                beats_d = (cur_dur == 3'd0) ? 3'd1 : cur_dur;
                cnt_d   = 28'd0;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (tick) begin
                    cnt_d   = 28'd0;
                    beats_d = beats_q - 3'd1;
                    if (beats_q <= 3'd1) begin
                        state_d = S_GAP;
                        en_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 28'd1;
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    cnt_d = 28'd0;
                    if (!last_step) begin
                        step_d  = step_q + 4'd1;
                        state_d = S_LOAD;
                    end else begin
`ifdef MELODY_LOOP_EN
                        if (loop) begin
                            step_d  = 4'd0;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 28'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
            end
        endcase

        // Abort wins over every transition above; the divisor is left as-is.
        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            step_d  = 4'd0;
            cnt_d   = 28'd0;
            beats_d = 3'd0;
            en_d    = 1'b0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: non-blocking assignments here so every register samples the pre-edge values of the others.
    always_ff @(posedge clock_in) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= 4'd0;
            cnt_q   <= 28'd0;
            beats_q <= 3'd0;
            div_q   <= 28'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            beats_q <= beats_d;
            div_q   <= div_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tone_divisor = div_q;
    assign tone_en      = en_q;
    assign step         = step_q;
    assign busy         = busy_q;
    assign done         = done_q;

    a_step_in_range: assert property (@(posedge clock_in) disable iff (!rst_n) step_q <= LAST_STEP);
    a_tone_needs_busy: assert property (@(posedge clock_in) disable iff (!rst_n) en_q |-> busy_q);
    a_done_single: assert property (@(posedge clock_in) disable iff (!rst_n) done_q |=> !done_q);

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: stimulus pushes expected output changes, a monitor pops and compares.
// Build with MELODY_LOOP_EN defined to also exercise the loop input.
module tb_melody_sequencer;

    localparam logic [27:0] TEMPO = 28'd10;
    localparam logic [27:0] GAP   = 28'd3;
    localparam int          LEN   = 8;
    localparam int          NEVER = 32'h3fff_ffff;

    typedef struct packed {
        logic [27:0] div;
        logic        en;
        logic [3:0]  step;
        logic        busy;
        logic        done;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t obs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
`ifdef MELODY_LOOP_EN
    logic        loop;
`endif
    logic [27:0] tone_divisor;
    logic        tone_en;
    logic [3:0]  step;
    logic        busy;
    logic        done;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cutoff   = NEVER;
    exp_t exp_q[$];
    obs_t model    = 'x;

    int song_code[LEN] = '{1, 3, 5, 6, 8, 0, 8, 1};
    int song_dur[LEN]  = '{2, 2, 2, 2, 4, 1, 4, 7};

    melody_sequencer #(
        .TEMPO_DIV (TEMPO),
        .GAP_CYCLES(GAP),
        .SONG_LEN  (LEN)
    ) dut (
        .clock_in    (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
`ifdef MELODY_LOOP_EN
        .loop        (loop),
`endif
        .tone_divisor(tone_divisor),
        .tone_en     (tone_en),
        .step        (step),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [27:0] note_div(input int code);
        case (code)
            1:  return 28'd91733;
            2:  return 28'd86586;
            3:  return 28'd81727;
            4:  return 28'd77138;
            5:  return 28'd72810;
            6:  return 28'd68723;
            7:  return 28'd64867;
            8:  return 28'd61224;
            9:  return 28'd57790;
            10: return 28'd54545;
            11: return 28'd51484;
            12: return 28'd48595;
            default: return 28'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Queue an expected output snapshot; snapshots equal to the previous one are not visible changes.
    task automatic push_exp(input int c, input obs_t o);
        exp_t e;
        if (c >= cutoff || o === model) return;
        e.cyc = c;
        e.obs = o;
        exp_q.push_back(e);
        model = o;
    endtask

    // Expected output changes for a song whose first LOAD is visible after edge s.
    task automatic model_song(input int s, input int passes);
        int   t;
        int   d;
        obs_t o;
        t = s;
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < LEN; k++) begin
                d = (song_dur[k] == 0) ? 1 : song_dur[k];
                o      = model;
                o.step = 4'(k);
                o.busy = 1'b1;
                o.en   = 1'b0;
                o.done = 1'b0;
                push_exp(t, o);
                o.div = note_div(song_code[k]);
                o.en  = (song_code[k] >= 1 && song_code[k] <= 12);
                push_exp(t + 1, o);
                o.en = 1'b0;
                push_exp(t + 1 + d * int'(TEMPO), o);
                t = t + 1 + d * int'(TEMPO) + int'(GAP);
            end
        end
        o      = model;
        o.done = 1'b1;
        push_exp(t, o);
        o.done = 1'b0;
        o.busy = 1'b0;
        push_exp(t + 1, o);
    endtask

    // Returns at the falling edge just before rising edge e, so inputs set now are sampled at e.
    task automatic wait_cycle(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    initial begin : monitor
        obs_t prev;
        obs_t cur;
        exp_t e;
        int   ev;
        prev = 'x;
        ev   = 0;
        forever begin
            @(negedge clk);
            cur = {tone_divisor, tone_en, step, busy, done};
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    check("output_stable", 64'(cur), 64'(prev));
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("ev%0d_outputs", ev), 64'(cur), 64'(e.obs));
                    check($sformatf("ev%0d_cycle", ev), 64'(cyc), 64'(e.cyc));
                end
                ev++;
                prev = cur;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not reach its end (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        obs_t o;
        int   end_cyc;
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
`ifdef MELODY_LOOP_EN
        loop  = 1'b0;
`endif
        push_exp(1, '0);
        wait_cycle(3);
        rst_n = 1'b1;

        // Full song from a one-cycle start at edge 5; a second start during step 2 must be ignored.
        wait_cycle(5);
        start = 1'b1;
        model_song(5, 1);
        wait_cycle(6);
        start = 1'b0;
        wait_cycle(60);
        start = 1'b1;
        wait_cycle(61);
        start = 1'b0;

        // start and stop together while idle: nothing may change.
        wait_cycle(290);
        start = 1'b1;
        stop  = 1'b1;
        wait_cycle(291);
        start = 1'b0;
        stop  = 1'b0;

        // Stop in the middle of step 4.
        wait_cycle(300);
        start  = 1'b1;
        cutoff = 412;
        model_song(300, 1);
        cutoff = NEVER;
        o      = model;
        o.en   = 1'b0;
        o.step = 4'd0;
        o.busy = 1'b0;
        o.done = 1'b0;
        push_exp(412, o);
        wait_cycle(301);
        start = 1'b0;
        wait_cycle(412);
        stop = 1'b1;
        wait_cycle(413);
        stop = 1'b0;

        // Replay from step 0, then a two-cycle reset during step 1.
        wait_cycle(420);
        start  = 1'b1;
        cutoff = 450;
        model_song(420, 1);
        cutoff = NEVER;
        push_exp(450, '0);
        wait_cycle(421);
        start = 1'b0;
        wait_cycle(450);
        rst_n = 1'b0;
        wait_cycle(452);
        rst_n = 1'b1;
        end_cyc = 470;

`ifdef MELODY_LOOP_EN
        // Loop once, drop loop during the second pass, which then ends with done.
        wait_cycle(460);
        loop  = 1'b1;
        start = 1'b1;
        model_song(460, 2);
        wait_cycle(461);
        start = 1'b0;
        wait_cycle(800);
        loop = 1'b0;
        end_cyc = 1020;
`endif

        wait_cycle(end_cyc);
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
